// File: rtl/fp_pkg.sv
// Shared floating-point helpers: field extraction, bias, canonical quiet NaN and flag layout.
// Functions work on a 64-bit container so one package serves every EXP_W/FRAC_W combination.
package fp_pkg;

    localparam int GRS_W   = 3;
    localparam int FLG_INV = 3;
    localparam int FLG_OVF = 2;
    localparam int FLG_UNF = 1;
    localparam int FLG_NX  = 0;

    function automatic logic [63:0] fp_exp(input logic [63:0] w, input int exp_w, input int frac_w);
        return (w >> frac_w) & ((64'd1 << exp_w) - 64'd1);
    endfunction

    function automatic logic [63:0] fp_frac(input logic [63:0] w, input int frac_w);
        return w & ((64'd1 << frac_w) - 64'd1);
    endfunction

    function automatic logic fp_sign(input logic [63:0] w, input int exp_w, input int frac_w);
        return 1'((w >> (exp_w + frac_w)) & 64'd1);
    endfunction

    function automatic int fp_bias(input int exp_w);
        return (1 << (exp_w - 1)) - 1;
    endfunction

    function automatic logic [63:0] fp_qnan(input int exp_w, input int frac_w);
        return (((64'd1 << exp_w) - 64'd1) << frac_w) | (64'd1 << (frac_w - 1));
    endfunction

endpackage

// File: rtl/fp_lzc.sv
// Combinational leading-zero counter; an all-zero input reports WIDTH.
module fp_lzc #(
    parameter int WIDTH = 27,
    localparam int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic [CNT_W-1:0] cnt_o
);

    // Scanning upward lets the highest set bit have the final say.
    always_comb begin
        cnt_o = CNT_W'(WIDTH);
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) cnt_o = CNT_W'(WIDTH - 1 - i);
        end
    end

endmodule

// File: rtl/fp_addsub_pipe.sv
// Three-stage floating-point adder/subtractor (align, add, normalise/round) with
// valid/ready flow control, round-to-nearest-even and exception flags.
module fp_addsub_pipe
    import fp_pkg::*;
#(
    parameter int EXP_W  = 8,
    parameter int FRAC_W = 23
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [EXP_W+FRAC_W:0]     in_a,
    input  logic [EXP_W+FRAC_W:0]     in_b,
    input  logic                      in_op,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [EXP_W+FRAC_W:0]     out_result,
    output logic [3:0]                out_flags
);

    localparam int W     = 1 + EXP_W + FRAC_W;
    localparam int M_W   = EXP_W + FRAC_W;
    localparam int SIG_W = FRAC_W + 1 + GRS_W;
    localparam int XW    = EXP_W + 2;
    localparam int LZW   = $clog2(SIG_W + 1);
    localparam logic [W-1:0] QNAN = W'(fp_qnan(EXP_W, FRAC_W));
    localparam logic signed [XW-1:0] E_INF = XW'((1 << EXP_W) - 1);

    function automatic logic [SIG_W-1:0] shr_sticky(input logic [SIG_W-1:0] v, input logic [EXP_W-1:0] sh);
        logic [SIG_W-1:0] r;
        logic             st;
        if (32'(sh) >= SIG_W) begin
            r  = '0;
            st = |v;
        end else begin
            r  = v >> sh;
            st = |(v & ~({SIG_W{1'b1}} << sh));
        end
        return {r[SIG_W-1:1], r[0] | st};
    endfunction

    function automatic logic [FRAC_W+1:0] rne(input logic [FRAC_W:0] m, input logic g, input logic st);
        return {1'b0, m} + (FRAC_W + 2)'(g & (st | m[0]));
    endfunction

    logic en1, en2, en3, accept;
    logic s1_vld_q, s2_vld_q, out_valid_q;
    logic [W-1:0] out_result_q, out_result_d;
    logic [3:0]   out_flags_q, out_flags_d;

    // A stage may load when everything after it moves, or when it holds a bubble.
    assign en3      = ~out_valid_q | out_ready;
    assign en2      = en3 | ~s2_vld_q;
    assign en1      = en2 | ~s1_vld_q;
    assign in_ready = rst_n & en3;
    assign accept   = in_valid & in_ready;

    // ---------------- S1: unpack, specials, swap, align ----------------
    logic [EXP_W-1:0]  a_ex, b_ex, big_ex, sm_ex, diff;
    logic [FRAC_W-1:0] a_fr, b_fr, big_fr, sm_fr;
    logic [M_W-1:0]    a_mag, b_mag;
    logic              a_sg, b_sg, a_max, b_max, swap, any_nan;

    assign a_ex  = EXP_W'(fp_exp(64'(in_a), EXP_W, FRAC_W));
    assign b_ex  = EXP_W'(fp_exp(64'(in_b), EXP_W, FRAC_W));
    assign a_fr  = FRAC_W'(fp_frac(64'(in_a), FRAC_W));
    assign b_fr  = FRAC_W'(fp_frac(64'(in_b), FRAC_W));
    assign a_sg  = fp_sign(64'(in_a), EXP_W, FRAC_W);
    assign b_sg  = fp_sign(64'(in_b), EXP_W, FRAC_W) ^ in_op;
    assign a_max = &a_ex;
    assign b_max = &b_ex;
    assign any_nan = (a_max & (|a_fr)) | (b_max & (|b_fr));

    assign a_mag = (a_ex == '0) ? '0 : {a_ex, a_fr};
    assign b_mag = (b_ex == '0) ? '0 : {b_ex, b_fr};
    assign swap  = b_mag > a_mag;
    assign {big_ex, big_fr} = swap ? b_mag : a_mag;
    assign {sm_ex, sm_fr}   = swap ? a_mag : b_mag;
    assign diff  = big_ex - sm_ex;

    logic              s1_sgb_d, s1_sgs_d, s1_spc_d;
    logic [EXP_W-1:0]  s1_exp_d;
    logic [SIG_W-1:0]  s1_sigb_d, s1_sigs_d;
    logic [W-1:0]      s1_spr_d;
    logic [3:0]        s1_spf_d;

    assign s1_sgb_d  = swap ? b_sg : a_sg;
    assign s1_sgs_d  = swap ? a_sg : b_sg;
    assign s1_exp_d  = big_ex;
    assign s1_sigb_d = {|big_ex, big_fr, {GRS_W{1'b0}}};
    assign s1_sigs_d = shr_sticky({|sm_ex, sm_fr, {GRS_W{1'b0}}}, diff);
    assign s1_spc_d  = a_max | b_max;

    always_comb begin
        s1_spr_d = QNAN;
        s1_spf_d = '0;
        if (!any_nan) begin
            if (a_max && b_max && (a_sg != b_sg)) s1_spf_d[FLG_INV] = 1'b1;
            else if (a_max) s1_spr_d = {a_sg, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            else if (b_max) s1_spr_d = {b_sg, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
        end
    end

    logic              s1_sgb_q, s1_sgs_q, s1_spc_q;
    logic [EXP_W-1:0]  s1_exp_q;
    logic [SIG_W-1:0]  s1_sigb_q, s1_sigs_q;
    logic [W-1:0]      s1_spr_q;
    logic [3:0]        s1_spf_q;

    always_ff @(posedge clk) begin
        if (en1) begin
            s1_sgb_q  <= s1_sgb_d;
            s1_sgs_q  <= s1_sgs_d;
            s1_exp_q  <= s1_exp_d;
            s1_sigb_q <= s1_sigb_d;
            s1_sigs_q <= s1_sigs_d;
            s1_spc_q  <= s1_spc_d;
            s1_spr_q  <= s1_spr_d;
            s1_spf_q  <= s1_spf_d;
        end
    end

    // ---------------- S2: significand add/subtract ----------------
    logic [SIG_W:0] s2_sum_d;
    logic           s2_sgn_d;

    assign s2_sum_d = (s1_sgb_q ^ s1_sgs_q) ? ({1'b0, s1_sigb_q} - {1'b0, s1_sigs_q})
                                            : ({1'b0, s1_sigb_q} + {1'b0, s1_sigs_q});
    // A zero sum is negative only when both addends were negative zeros.
    assign s2_sgn_d = (s2_sum_d == '0) ? (s1_sgb_q & s1_sgs_q) : s1_sgb_q;

    logic [SIG_W:0]    s2_sum_q;
    logic              s2_sgn_q, s2_spc_q;
    logic [EXP_W-1:0]  s2_exp_q;
    logic [W-1:0]      s2_spr_q;
    logic [3:0]        s2_spf_q;

    always_ff @(posedge clk) begin
        if (en2) begin
            s2_sum_q <= s2_sum_d;
            s2_sgn_q <= s2_sgn_d;
            s2_exp_q <= s1_exp_q;
            s2_spc_q <= s1_spc_q;
            s2_spr_q <= s1_spr_q;
            s2_spf_q <= s1_spf_q;
        end
    end

    // ---------------- S3: normalise, round, pack ----------------
    logic [LZW-1:0] lz;

    fp_lzc #(.WIDTH(SIG_W)) u_lzc (
        .vec_i (s2_sum_q[SIG_W-1:0]),
        .cnt_o (lz)
    );

    logic [SIG_W-1:0]        norm;
    logic signed [XW-1:0]    e_big, lz_s, e_n, e_r;
    logic [FRAC_W+1:0]       mant_r;
    logic [FRAC_W-1:0]       frac_r;
    logic                    g, st;

    always_comb begin
        e_big = XW'(s2_exp_q);
        lz_s  = XW'(lz);
        if (s2_sum_q[SIG_W]) begin
            norm = {s2_sum_q[SIG_W:2], s2_sum_q[1] | s2_sum_q[0]};
            e_n  = e_big + XW'(1);
        end else begin
            norm = s2_sum_q[SIG_W-1:0] << lz;
            e_n  = e_big - lz_s;
        end
        g      = norm[GRS_W-1];
        st     = |norm[GRS_W-2:0];
        mant_r = rne(norm[SIG_W-1:GRS_W], g, st);
        if (mant_r[FRAC_W+1]) begin
            e_r    = e_n + XW'(1);
            frac_r = mant_r[FRAC_W:1];
        end else begin
            e_r    = e_n;
            frac_r = mant_r[FRAC_W-1:0];
        end

        out_result_d = {s2_sgn_q, e_r[EXP_W-1:0], frac_r};
        out_flags_d  = '0;
        out_flags_d[FLG_NX] = g | st;
        if (s2_spc_q) begin
            out_result_d = s2_spr_q;
            out_flags_d  = s2_spf_q;
        end else if (s2_sum_q == '0) begin
            out_result_d = {s2_sgn_q, {M_W{1'b0}}};
            out_flags_d  = '0;
        end else if (e_r >= E_INF) begin
            out_result_d = {s2_sgn_q, {EXP_W{1'b1}}, {FRAC_W{1'b0}}};
            out_flags_d  = '0;
            out_flags_d[FLG_OVF] = 1'b1;
            out_flags_d[FLG_NX]  = 1'b1;
        end else if (e_r[XW-1] || (e_r == '0)) begin
            out_result_d = {s2_sgn_q, {M_W{1'b0}}};
            out_flags_d  = '0;
            out_flags_d[FLG_UNF] = 1'b1;
            out_flags_d[FLG_NX]  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_vld_q     <= 1'b0;
            s2_vld_q     <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_flags_q  <= '0;
        end else begin
            if (en1) s1_vld_q <= accept;
            if (en2) s2_vld_q <= s1_vld_q;
            if (en3) out_valid_q <= s2_vld_q;
            if (en3 && s2_vld_q) begin
                out_result_q <= out_result_d;
                out_flags_q  <= out_flags_d;
            end
        end
    end

    assign out_valid  = out_valid_q;
    assign out_result = out_result_q;
    assign out_flags  = out_flags_q;

endmodule

// File: tb/tb_fp_addsub_pipe.sv
// Scoreboard bench for fp_addsub_pipe: directed single-precision vectors, stall and reset scenarios.
module tb_fp_addsub_pipe;

    localparam int EXP_W  = 8;
    localparam int FRAC_W = 23;
    localparam int W      = 1 + EXP_W + FRAC_W;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, in_valid, in_ready, in_op, out_valid, out_ready;
    logic [W-1:0] in_a, in_b, out_result;
    logic [3:0]   out_flags;

    fp_addsub_pipe #(.EXP_W(EXP_W), .FRAC_W(FRAC_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_a       (in_a),
        .in_b       (in_b),
        .in_op      (in_op),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_flags  (out_flags)
    );

    typedef struct {
        logic [31:0] res;
        logic [3:0]  flg;
        bit          lat;
        int          acc;
        int          id;
    } exp_t;

    exp_t sb[$];
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   next_id = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Present one pair; the handshake edge is the posedge after in_ready is seen high.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic op,
                        input logic [31:0] r, input logic [3:0] f, input bit lat);
        exp_t e;
        int   waitc = 0;
        @(negedge clk);
        in_valid = 1'b1;
        in_a     = a;
        in_b     = b;
        in_op    = op;
        #1;
        while (!in_ready && waitc < 100) begin
            @(negedge clk);
            #1;
            waitc++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=in_ready_low expected=accept a=%h b=%h", a, b);
        end else begin
            e.res = r;
            e.flg = f;
            e.lat = lat;
            e.acc = cyc;
            e.id  = next_id;
            next_id++;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("drain_pending", 32'(sb.size()), 32'd0);
    endtask

    // Monitor: checks the ready rule, output stability under stall, and pops on every transfer.
    initial begin
        exp_t        e;
        logic [31:0] held_res;
        logic [3:0]  held_flg;
        bit          stall_prev;
        stall_prev = 1'b0;
        held_res   = '0;
        held_flg   = '0;
        forever begin
            @(negedge clk);
            #2;
            if (cyc > 0)
                chk("in_ready_rule", {31'b0, in_ready}, {31'b0, rst_n & (~out_valid | out_ready)});
            if (stall_prev && out_valid) begin
                chk("hold_result", out_result, held_res);
                chk("hold_flags", {28'b0, out_flags}, {28'b0, held_flg});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output got=%h expected=no_output", out_result);
                end else begin
                    e = sb.pop_front();
                    chk($sformatf("vec%0d_result", e.id), out_result, e.res);
                    chk($sformatf("vec%0d_flags", e.id), {28'b0, out_flags}, {28'b0, e.flg});
                    if (e.lat) chk($sformatf("vec%0d_latency", e.id), 32'(cyc - e.acc), 32'd3);
                end
            end
            stall_prev = out_valid && !out_ready;
            held_res   = out_result;
            held_flg   = out_flags;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_op     = 1'b0;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_result", out_result, 32'd0);
        chk("rst_out_flags", {28'b0, out_flags}, 32'd0);
        rst_n = 1'b1;

        // Exact cancellation with latency check on an empty pipe.
        send(32'h3FC00000, 32'hBFC00000, 1'b0, 32'h00000000, 4'b0000, 1'b1);
        idle();
        drain();

        // Sums, ties, specials, overflow and underflow back to back.
        send(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000, 1'b0);
        send(32'h3FC00000, 32'h3FC00000, 1'b1, 32'h00000000, 4'b0000, 1'b0);
        send(32'h3F800000, 32'h33800000, 1'b0, 32'h3F800000, 4'b0001, 1'b0);
        send(32'h3F800001, 32'h33800000, 1'b0, 32'h3F800002, 4'b0001, 1'b0);
        send(32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 4'b1000, 1'b0);
        send(32'h7F7FFFFF, 32'h7F7FFFFF, 1'b0, 32'h7F800000, 4'b0101, 1'b0);
        send(32'h7FC00001, 32'h3F800000, 1'b0, 32'h7FC00000, 4'b0000, 1'b0);
        send(32'h7F800000, 32'h3F800000, 1'b1, 32'h7F800000, 4'b0000, 1'b0);
        send(32'h00800000, 32'h00C00000, 1'b1, 32'h80000000, 4'b0011, 1'b0);
        idle();
        drain();

        // Eight-pair stream with the output stalled for six cycles.
        fork
            begin
                send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 1'b0);
                send(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000, 1'b0);
                send(32'h40400000, 32'h3F800000, 1'b0, 32'h40800000, 4'b0000, 1'b0);
                send(32'h40800000, 32'h3F800000, 1'b1, 32'h40400000, 4'b0000, 1'b0);
                send(32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4'b0000, 1'b0);
                send(32'h41200000, 32'h3F000000, 1'b0, 32'h41280000, 4'b0000, 1'b0);
                send(32'h00000000, 32'h80000000, 1'b0, 32'h00000000, 4'b0000, 1'b0);
                send(32'h80000000, 32'h80000000, 1'b0, 32'h80000000, 4'b0000, 1'b0);
                idle();
            end
            begin
                repeat (4) @(negedge clk);
                out_ready = 1'b0;
                repeat (6) @(negedge clk);
                out_ready = 1'b1;
            end
        join
        drain();

        // Reset with three pairs in flight: none of them may come out.
        out_ready = 1'b0;
        send(32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 4'b0000, 1'b0);
        send(32'h40000000, 32'h3F800000, 1'b0, 32'h40400000, 4'b0000, 1'b0);
        send(32'h3F800000, 32'h3F800000, 1'b0, 32'h40000000, 4'b0000, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        sb.delete();
        #1;
        chk("rst_mid_in_ready", {31'b0, in_ready}, 32'd0);
        @(negedge clk);
        rst_n     = 1'b1;
        out_ready = 1'b1;
        #1;
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        send(32'h40000000, 32'h40000000, 1'b0, 32'h40800000, 4'b0000, 1'b1);
        idle();
        drain();
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
